// File: rtl/map_pkg.sv
// -----------------------------------------------------------------------------
// map_pkg
// Shared definitions for the tile-map controller: map geometry, tile codes,
// controller FSM states and the tile toggle rule applied by player edits.
// No ports (package).
// -----------------------------------------------------------------------------
package map_pkg;

  localparam int MAP_W     = 20;
  localparam int MAP_H     = 15;
  localparam int MAP_CELLS = MAP_W * MAP_H;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    BORDER = 3'd1,
    BRICK  = 3'd2,
    GOAL1  = 3'd3,
    GOAL2  = 3'd4,
    SOFT   = 3'd5,
    ICE    = 3'd6
  } tile_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EDIT_RD = 2'd1,
    EDIT_WR = 2'd2,
    LOAD    = 2'd3
  } state_t;

  // Result of applying a toggle to one tile: whether to write, and what.
  typedef struct packed {
    logic       we;
    logic [2:0] val;
  } toggle_t;

  // Brick/ice clear to empty, empty/soft become brick. Border, goals and the
  // unused code 7 are immutable, so no write is requested for them.
  function automatic toggle_t toggle_tile(input logic [2:0] tile);
    toggle_t r;
    r.we  = 1'b0;
    r.val = tile;
    case (tile)
      BRICK, ICE: begin
        r.we  = 1'b1;
        r.val = EMPTY;
      end
      EMPTY, SOFT: begin
        r.we  = 1'b1;
        r.val = BRICK;
      end
      default: begin
        r.we  = 1'b0;
        r.val = tile;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. The grant is combinational from the
// request vector and the last-grant register; the register only moves when
// the owner commits the grant (advance high).
// Ports:
//   Clk, Reset   clock, synchronous active-high reset (last grant = req[1])
//   req[1:0]     request vector (bit 0 = player 1, bit 1 = player 2)
//   advance      grant is being taken this cycle; update last-grant
//   gnt[1:0]     one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 0 = requester 0 granted last, 1 = requester 1 granted last
  logic last_reg;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_reg ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Requester 0 wins the first tie after reset.
      last_reg <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/map_controller.sv
// -----------------------------------------------------------------------------
// map_controller
// Owns the single-port map RAM. Streams whole levels from the level ROM into
// the RAM and serialises two players' tile-toggle requests as read-modify-
// write edits. Level loads (including the win screen) take priority over
// edits and are remembered if they arrive mid-edit.
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   reqN_valid/idx/ready       player N toggle request (idx = row*20+col)
//   load_req, load_level       load level command
//   win                        load the blank win-screen level (last slot)
//   rom_addr, rom_data         level ROM, 1-cycle read latency
//   ram_addr/rdata/we/wdata    map RAM, 1-cycle read latency
//   busy                       high whenever not idle
//   load_done                  pulse on the final load write
//   edit_done, edit_id         pulse on edit completion, 0=player1 1=player2
// -----------------------------------------------------------------------------
module map_controller #(
  parameter int MAP_CELLS  = 300,
  parameter int NUM_LEVELS = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req1_valid,
  input  logic        req2_valid,
  input  logic [8:0]  req1_idx,
  input  logic [8:0]  req2_idx,
  output logic        req1_ready,
  output logic        req2_ready,
  input  logic        load_req,
  input  logic [1:0]  load_level,
  input  logic        win,
  output logic [10:0] rom_addr,
  input  logic [2:0]  rom_data,
  output logic [8:0]  ram_addr,
  input  logic [2:0]  ram_rdata,
  output logic        ram_we,
  output logic [2:0]  ram_wdata,
  output logic        busy,
  output logic        load_done,
  output logic        edit_done,
  output logic        edit_id
);

  import map_pkg::*;

  localparam logic [8:0]  LAST_CNT  = 9'(MAP_CELLS);
  localparam logic [10:0] CELLS_W   = 11'(MAP_CELLS);
  localparam logic [1:0]  WIN_LEVEL = 2'(NUM_LEVELS - 1);

  state_t      state_reg;
  logic [8:0]  cnt_reg;       // load cycle index, 0..MAP_CELLS
  logic [10:0] base_reg;      // level * MAP_CELLS, fixed for one load
  logic        pend_reg;      // load requested but not yet started
  logic [1:0]  pend_lvl_reg;
  logic [8:0]  idx_reg;       // cell under edit
  logic        id_reg;        // player owning the edit

  // A fresh load_req carries its own level even when win fires alongside.
  logic       load_now;
  logic [1:0] new_lvl;
  logic       idle_load;
  logic [1:0] start_lvl;
  logic       grant_ok;
  logic [1:0] gnt;
  logic       idx_ok;
  toggle_t    edit_rule;

  assign load_now  = load_req | win;
  assign new_lvl   = load_req ? load_level : WIN_LEVEL;
  assign idle_load = pend_reg | load_now;
  assign start_lvl = load_now ? new_lvl : pend_lvl_reg;

  // Requests are only accepted in IDLE with nothing waiting to load.
  assign grant_ok  = (state_reg == IDLE) && !idle_load && !Reset;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .req     ({req2_valid, req1_valid}),
    .advance (grant_ok),
    .gnt     (gnt)
  );

  assign req1_ready = grant_ok & gnt[0];
  assign req2_ready = grant_ok & gnt[1];

  assign idx_ok    = (idx_reg < LAST_CNT);
  assign edit_rule = toggle_tile(ram_rdata);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Power-up behaves like a pending load of level 0.
      state_reg    <= IDLE;
      cnt_reg      <= 9'd0;
      base_reg     <= 11'd0;
      pend_reg     <= 1'b1;
      pend_lvl_reg <= 2'd0;
      idx_reg      <= 9'd0;
      id_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (idle_load) begin
            state_reg <= LOAD;
            cnt_reg   <= 9'd0;
            base_reg  <= 11'(start_lvl) * CELLS_W;
            pend_reg  <= 1'b0;
          end else if (gnt != 2'b00) begin
            state_reg <= EDIT_RD;
            idx_reg   <= gnt[0] ? req1_idx : req2_idx;
            id_reg    <= ~gnt[0];
          end
        end
        EDIT_RD: begin
          if (load_now) begin
            pend_reg     <= 1'b1;
            pend_lvl_reg <= new_lvl;
          end
          state_reg <= EDIT_WR;
        end
        EDIT_WR: begin
          if (load_now) begin
            pend_reg     <= 1'b1;
            pend_lvl_reg <= new_lvl;
          end
          state_reg <= IDLE;
        end
        LOAD: begin
          // Load commands are dropped here: pend_reg is left untouched.
          if (cnt_reg == LAST_CNT) begin
            state_reg <= IDLE;
            cnt_reg   <= 9'd0;
          end else begin
            cnt_reg <= cnt_reg + 9'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state. Write data follows the memory read
  // data of the same cycle (ROM for loads, RAM for edits), so it cannot be
  // registered without adding a cycle. Everything is forced low while Reset
  // is asserted so an interrupted load or edit stops writing immediately.
  always_comb begin
    rom_addr  = 11'd0;
    ram_addr  = 9'd0;
    ram_we    = 1'b0;
    ram_wdata = 3'd0;
    busy      = 1'b0;
    load_done = 1'b0;
    edit_done = 1'b0;
    edit_id   = 1'b0;
    if (!Reset) begin
      case (state_reg)
        EDIT_RD: begin
          busy = 1'b1;
          if (idx_ok) begin
            ram_addr = idx_reg;
          end
        end
        EDIT_WR: begin
          busy      = 1'b1;
          edit_done = 1'b1;
          edit_id   = id_reg;
          if (idx_ok) begin
            ram_addr  = idx_reg;
            ram_we    = edit_rule.we;
            ram_wdata = edit_rule.val;
          end
        end
        LOAD: begin
          busy = 1'b1;
          // ROM address leads the RAM write by one cycle.
          if (cnt_reg != LAST_CNT) begin
            rom_addr = base_reg + 11'(cnt_reg);
          end
          if (cnt_reg != 9'd0) begin
            ram_we    = 1'b1;
            ram_addr  = cnt_reg - 9'd1;
            ram_wdata = rom_data;
          end
          load_done = (cnt_reg == LAST_CNT);
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_map_controller.sv
// -----------------------------------------------------------------------------
// tb_map_controller
// Directed bench for map_controller with behavioural ROM/RAM models. Expected
// RAM writes and edit completions are queued when stimulus is applied and
// popped by a monitor when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_map_controller;

  logic        Clk;
  logic        Reset;
  logic        req1_valid, req2_valid;
  logic [8:0]  req1_idx, req2_idx;
  logic        req1_ready, req2_ready;
  logic        load_req;
  logic [1:0]  load_level;
  logic        win;
  logic [10:0] rom_addr;
  logic [2:0]  rom_data;
  logic [8:0]  ram_addr;
  logic [2:0]  ram_rdata;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic        busy, load_done, edit_done, edit_id;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_wr_q[$];   // {addr, data}
  logic        exp_id_q[$];
  logic [2:0]  model_map [0:299];
  logic [2:0]  mem [0:511];

  map_controller #(.MAP_CELLS(300), .NUM_LEVELS(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .req1_valid (req1_valid),
    .req2_valid (req2_valid),
    .req1_idx   (req1_idx),
    .req2_idx   (req2_idx),
    .req1_ready (req1_ready),
    .req2_ready (req2_ready),
    .load_req   (load_req),
    .load_level (load_level),
    .win        (win),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .ram_addr   (ram_addr),
    .ram_rdata  (ram_rdata),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .busy       (busy),
    .load_done  (load_done),
    .edit_done  (edit_done),
    .edit_id    (edit_id)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Level contents: border ring of 1, goals at cells 29/30, fixed tiles at
  // 45/46, a level-dependent pattern elsewhere; level 3 is all empty.
  function automatic logic [2:0] rom_val(input int a);
    int lv, k, r, c;
    lv = a / 300;
    k  = a % 300;
    r  = k / 20;
    c  = k % 20;
    if (lv >= 3) return 3'd0;
    if (r == 0 || r == 14 || c == 0 || c == 19) return 3'd1;
    if (k == 29) return 3'd4;
    if (k == 30) return 3'd3;
    if (k == 45) return 3'd0;
    if (k == 46) return 3'd2;
    case ((k + lv) % 4)
      0:       return 3'd0;
      1:       return 3'd2;
      2:       return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  always @(posedge Clk) begin
    rom_data <= rom_val(int'(rom_addr));
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Monitor: every write and edit completion must match the scoreboard.
  always @(negedge Clk) begin
    logic [11:0] e;
    logic        eid;
    if (Reset === 1'b1) begin
      checks++;
      assert (ram_we === 1'b0) else begin
        errors++;
        $error("FAIL we_in_reset obs=%b exp=0", ram_we);
      end
    end else if (ram_we === 1'b1) begin
      checks++;
      assert (exp_wr_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write obs=addr %0d data %0d exp=no write", ram_addr, ram_wdata);
      end
      if (exp_wr_q.size() != 0) begin
        e = exp_wr_q.pop_front();
        checks++;
        assert ({ram_addr, ram_wdata} === e) else begin
          errors++;
          $error("FAIL ram_write obs=addr %0d data %0d exp=addr %0d data %0d",
                 ram_addr, ram_wdata, e[11:3], e[2:0]);
        end
      end
    end
    if (edit_done === 1'b1) begin
      checks++;
      assert (exp_id_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_edit_done obs=id %0d exp=none", edit_id);
      end
      if (exp_id_q.size() != 0) begin
        eid = exp_id_q.pop_front();
        checks++;
        assert (edit_id === eid) else begin
          errors++;
          $error("FAIL edit_id obs=%0d exp=%0d", edit_id, eid);
        end
        $display("edit  done id=%0d cell=%0d we=%0b", edit_id, ram_addr, ram_we);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Queue the 300 writes of a level and update the shadow map.
  task automatic push_load(input int lvl);
    for (int k = 0; k < 300; k++) begin
      exp_wr_q.push_back({9'(k), rom_val(lvl * 300 + k)});
      model_map[k] = rom_val(lvl * 300 + k);
    end
  endtask

  // Queue the outcome of a toggle on idx by player id.
  task automatic push_edit(input int idx, input logic id);
    logic [2:0] t;
    exp_id_q.push_back(id);
    if (idx < 300) begin
      t = model_map[idx];
      if (t == 3'd2 || t == 3'd6) begin
        exp_wr_q.push_back({9'(idx), 3'd0});
        model_map[idx] = 3'd0;
      end else if (t == 3'd0 || t == 3'd5) begin
        exp_wr_q.push_back({9'(idx), 3'd2});
        model_map[idx] = 3'd2;
      end
    end
  endtask

  // Called in LOAD cycle 0; walks all 301 load cycles, returns in IDLE.
  task automatic run_load(input int base);
    int bad;
    bad = 0;
    for (int c = 0; c <= 300; c++) begin
      if (c < 300 && rom_addr !== 11'(base + c)) bad++;
      if (load_done !== (c == 300)) bad++;
      if (busy !== 1'b1) bad++;
      if (req1_ready !== 1'b0 || req2_ready !== 1'b0) bad++;
      step();
    end
    check($sformatf("load_seq_base%0d", base), bad, 0);
    check("load_then_idle", busy, 1'b0);
    $display("load  done base=%0d bad_cycles=%0d", base, bad);
  endtask

  // Player 1 single edit; returns in IDLE after the edit.
  task automatic do_edit1(input int idx);
    int n;
    req1_valid = 1'b1;
    req1_idx   = 9'(idx);
    #1;
    n = 0;
    while (req1_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("grant_wait", (n < 20), 1'b1);
    push_edit(idx, 1'b0);
    step();
    req1_valid = 1'b0;
    step();
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 3'd0;
    Reset = 1'b1;
    req1_valid = 1'b1; req1_idx = 9'd45;
    req2_valid = 1'b0; req2_idx = 9'd0;
    load_req = 1'b0; load_level = 2'd0; win = 1'b0;
    step();
    step();
    check("rst_flags", {busy, ram_we, req1_ready, req2_ready, load_done, edit_done, edit_id}, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ram_addr", ram_addr, 0);

    // Cycle after reset: idle, load pending, request must not be accepted.
    push_load(0);
    Reset = 1'b0;
    #1;
    check("post_rst_flags", {busy, ram_we, req1_ready, req2_ready, load_done}, 0);
    req1_valid = 1'b0;
    step();
    run_load(0);

    // Tie between players: player 1 first, then player 2.
    req1_valid = 1'b1; req1_idx = 9'd45;
    req2_valid = 1'b1; req2_idx = 9'd46;
    #1;
    check("tie_first_grant", {req2_ready, req1_ready}, 2'b01);
    push_edit(45, 1'b0);
    step();
    req1_valid = 1'b0;
    #1;
    check("edit_rd_addr", ram_addr, 45);
    check("edit_rd_ready", {req2_ready, req1_ready, ram_we, busy}, 4'b0001);
    step();
    check("edit_wr_done", edit_done, 1'b1);
    step();
    check("tie_second_grant", {req2_ready, req1_ready}, 2'b10);
    push_edit(46, 1'b1);
    step();
    req2_valid = 1'b0;
    step();
    step();
    check("cell45", mem[45], 3'd2);
    check("cell46", mem[46], 3'd0);

    // Immutable tiles and an out-of-range index.
    do_edit1(0);
    do_edit1(29);
    do_edit1(310);
    check("imm_cell0", mem[0], 3'd1);
    check("imm_cell29", mem[29], 3'd4);

    // Win during EDIT_RD: edit finishes, then win screen loads.
    req1_valid = 1'b1; req1_idx = 9'd50;
    #1;
    check("win_edit_grant", req1_ready, 1'b1);
    push_edit(50, 1'b0);
    step();
    req1_valid = 1'b0;
    win = 1'b1;
    #1;
    check("win_rd_addr", ram_addr, 50);
    step();
    win = 1'b0;
    push_load(3);
    step();
    check("win_idle_busy", busy, 1'b0);
    step();
    run_load(900);
    check("win_cell0_blank", mem[0], 3'd0);

    // load_req wins over simultaneous win; held request waits out the load.
    load_req = 1'b1; load_level = 2'd2; win = 1'b1;
    req1_valid = 1'b1; req1_idx = 9'd47;
    #1;
    check("ready_load_pending", req1_ready, 1'b0);
    push_load(2);
    step();
    load_req = 1'b0; win = 1'b0;
    run_load(600);
    check("ready_after_load", req1_ready, 1'b1);
    push_edit(47, 1'b0);
    step();
    req1_valid = 1'b0;
    step();
    step();
    check("cell47_l2", mem[47], model_map[47]);

    // Reset in the middle of a load abandons it and restarts level 0.
    load_req = 1'b1; load_level = 2'd1;
    push_load(1);
    step();
    load_req = 1'b0;
    for (int c = 0; c < 150; c++) step();
    check("mid_load_rom_addr", rom_addr, 450);
    Reset = 1'b1;
    #1;
    check("mid_rst_outs", {ram_we, busy, load_done}, 0);
    check("mid_rst_rom_addr", rom_addr, 0);
    check("mid_rst_remaining", exp_wr_q.size(), 151);
    exp_wr_q.delete();
    step();
    step();
    Reset = 1'b0;
    push_load(0);
    #1;
    check("restart_idle", {busy, ram_we}, 0);
    step();
    run_load(0);

    check("wr_queue_empty", exp_wr_q.size(), 0);
    check("id_queue_empty", exp_id_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
